fetch_pc_predictor: RTL
=======================

# fetch_pc_predictor

Parametrised next-PC generator for the fetch stage. It owns the architectural fetch PC register and predicts conditional branch direction with a table of saturating counters indexed by PC. It resolves mispredictions and indirect jumps reported by the execute stage, and keeps branch and mispredict performance counters. It replaces the single-bit, last-outcome next-PC selection with a trained, table-based predictor that stalls and redirects on its own.

## Interface
- RESET_PC, 32'h4000_0000, fetch PC loaded on reset
- BHT_ENTRIES, 64, counter-table depth; power of two, 2..1024
- CTR_BITS, 2, width of each saturating counter; 1..4
- clk  input  1  single clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- bp_enable  input  1  1 = use the table prediction; 0 = always predict not-taken
- stall  input  1  holds the PC; redirects are not affected
- f_is_br  input  1  the instruction at `pc` is a conditional branch
- f_is_jal  input  1  the instruction at `pc` is a JAL
- f_target  input  32  pc + imm for the instruction at `pc`
- x_br_valid  input  1  the execute stage resolved a conditional branch this cycle
- x_pc  input  32  PC of the resolving branch
- x_taken  input  1  actual branch outcome
- x_pred_taken  input  1  prediction carried down the pipe with that branch
- x_target  input  32  branch target computed by the ALU
- x_is_jalr  input  1  the execute stage holds a JALR
- x_jalr_target  input  32  JALR target with bit 0 cleared
- pc  output  32  current fetch PC (registered)
- next_pc  output  32  value `pc` takes at the next edge (combinational)
- pred_taken  output  1  prediction for the instruction at `pc`
- flush  output  1  squash the younger fetch and decode instructions this cycle
- perf_branches  output  32  count of resolved conditional branches
- perf_mispredicts  output  32  count of mispredicted conditional branches

## Operation
- Index: idx = pc[IDX+1:2], with IDX = log2(BHT_ENTRIES). The update index uses x_pc the same way.
- Lookup: pred_taken = bp_enable & f_is_br & counter[idx][CTR_BITS-1] (counter MSB).
- Mispredict: mispred = x_br_valid & (x_taken != x_pred_taken).
- Redirect target on mispredict:
  - x_taken = 1: x_target.
  - x_taken = 0: x_pc + 4.
- Flush: flush = mispred | x_is_jalr.
- next_pc priority, highest first:
  1. rst: RESET_PC.
  2. mispred: redirect target above.
  3. x_is_jalr: x_jalr_target.
  4. stall: pc.
  5. f_is_jal: f_target.
  6. pred_taken: f_target.
  7. otherwise: pc + 4.
- Table update, when x_br_valid & ~rst:
  - x_taken = 1: counter increments, saturating at 2^CTR_BITS-1.
  - x_taken = 0: counter decrements, saturating at 0.
- The table trains even when bp_enable = 0.
- perf_branches increments on x_br_valid; perf_mispredicts increments on mispred. Both wrap modulo 2^32.
- x_pred_taken is produced by this block in an earlier cycle and travels down the pipe. This block stores no per-branch state.
- All adders are 32-bit with carry dropped. pc + 4 from 32'hFFFF_FFFC yields 32'h0000_0000.

## Timing
- Reset, on the edge where rst = 1:
  - pc = RESET_PC.
  - Every counter = weakly not-taken, 2^(CTR_BITS-1)-1 (value 01 for 2 bits, 0 for 1 bit).
  - Both perf counters = 0.
  - While rst is high: flush = 0, pred_taken = 0, next_pc = RESET_PC.
- Reset mid-operation: a branch resolving in the same cycle as rst neither trains the table nor counts.
- Lookup is combinational on the current pc. Prediction and redirect both take effect at the next edge: zero-bubble taken path for predicted branches and JAL.
- Mispredict or JALR costs exactly one flush cycle. flush is asserted in the same cycle as the resolve inputs, and the correct PC appears in pc one edge later.
- Same-index read/update in the same cycle: the lookup sees the old counter value; the new value is visible from the next cycle.
- Simultaneous mispred and x_is_jalr: the mispredict target wins. This is illegal from a single execute stage; the bench checks the priority only.
- stall with a redirect: the redirect wins and the PC is not held.
- At counter saturation, a further same-direction update leaves the value unchanged.

## Test plan
- Reset: drive rst for 2 cycles then release, with RESET_PC default -> pc = 32'h4000_0000; the first lookup of any PC with f_is_br = 1 gives pred_taken = 0; both perf counters = 0.
- Training (defaults): resolve a branch at x_pc = 32'h4000_0010 taken twice -> the counter steps 01→10→11, a later fetch of pc 32'h4000_0010 with f_is_br = 1 gives pred_taken = 1, and next_pc = f_target.
- Saturation (CTR_BITS = 2): resolve the same branch taken 5 times, then not-taken once -> the counter holds at 11, then reads 10, and the prediction is still taken.
- Mispredict: x_br_valid = 1, x_pred_taken = 1, x_taken = 0, x_pc = 32'h4000_0100 -> flush = 1 that cycle, pc = 32'h4000_0104 next cycle, perf_mispredicts increments by 1.
- Priority: assert stall with f_is_jal = 1 and x_is_jalr = 1, x_jalr_target = 32'h4000_2000 -> flush = 1, pc = 32'h4000_2000. Repeat with only stall -> pc is unchanged over 3 cycles.
- bp_enable = 0 with a saturated-taken entry -> pred_taken = 0; resolving that branch as taken yields a mispredict and the counter stays at 11.

Source files
------------

// File: rtl/fetch_pc_predictor.sv
// Fetch-stage next-PC generator with a PC-indexed table of saturating
// direction counters, execute-stage redirect handling and perf counters.
module fetch_pc_predictor #(
   parameter logic [31:0] RESET_PC    = 32'h4000_0000,
   parameter int          BHT_ENTRIES = 64,
   parameter int          CTR_BITS    = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        bp_enable,
   input  logic        stall,
   input  logic        f_is_br,
   input  logic        f_is_jal,
   input  logic [31:0] f_target,
   input  logic        x_br_valid,
   input  logic [31:0] x_pc,
   input  logic        x_taken,
   input  logic        x_pred_taken,
   input  logic [31:0] x_target,
   input  logic        x_is_jalr,
   input  logic [31:0] x_jalr_target,
   output logic [31:0] pc,
   output logic [31:0] next_pc,
   output logic        pred_taken,
   output logic        flush,
   output logic [31:0] perf_branches,
   output logic [31:0] perf_mispredicts
);

   localparam int IDX = $clog2(BHT_ENTRIES);
   localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
   localparam logic [CTR_BITS-1:0] CTR_ZERO = '0;
   localparam logic [CTR_BITS-1:0] CTR_ONE  = CTR_BITS'(1);
   // Weakly not-taken: all ones shifted right gives 2^(CTR_BITS-1)-1.
   localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_MAX >> 1;

   logic [CTR_BITS-1:0] bht [BHT_ENTRIES];
   logic [IDX-1:0]      rd_idx;
   logic [IDX-1:0]      wr_idx;
   logic                mispred;
   logic [31:0]         redirect_target;

   assign rd_idx = pc[IDX+1:2];
   assign wr_idx = x_pc[IDX+1:2];

   always_comb begin
      pred_taken      = 1'b0;
      mispred         = 1'b0;
      flush           = 1'b0;
      redirect_target = x_taken ? x_target : x_pc + 32'd4;
      if (!rst) begin
         pred_taken = bp_enable & f_is_br & bht[rd_idx][CTR_BITS-1];
         mispred    = x_br_valid & (x_taken != x_pred_taken);
         flush      = mispred | x_is_jalr;
      end
   end

   // Redirects from execute outrank stall; stall outranks fetch-side jumps.
   always_comb begin
      next_pc = pc + 32'd4;
      if (rst)
         next_pc = RESET_PC;
      else if (mispred)
         next_pc = redirect_target;
      else if (x_is_jalr)
         next_pc = x_jalr_target;
      else if (stall)
         next_pc = pc;
      else if (f_is_jal || pred_taken)
         next_pc = f_target;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc               <= RESET_PC;
         perf_branches    <= 32'd0;
         perf_mispredicts <= 32'd0;
         for (int i = 0; i < BHT_ENTRIES; i++)
            bht[i] <= CTR_INIT;
      end else begin
         pc <= next_pc;
         if (x_br_valid) begin
            perf_branches <= perf_branches + 32'd1;
            if (x_taken && bht[wr_idx] != CTR_MAX)
               bht[wr_idx] <= bht[wr_idx] + CTR_ONE;
            else if (!x_taken && bht[wr_idx] != CTR_ZERO)
               bht[wr_idx] <= bht[wr_idx] - CTR_ONE;
         end
         if (mispred)
            perf_mispredicts <= perf_mispredicts + 32'd1;
      end
   end

endmodule
